gshare_pht: RTL
===============

Name: gshare_pht

Overview:
- Gshare branch direction predictor: a pattern history table (PHT) of 2-bit saturating counters, indexed by the fetch PC XORed with a global history register (GHR).
- The fetch stage reads a direction prediction in the same cycle and carries the PHT index down the pipeline.
- At branch resolution, execute returns that index with the outcome. The block then performs the counter read-modify-write, shifts the GHR and updates the statistics counters.

Parameters:
IDX_WIDTH, 7, PHT index width; table holds 2^IDX_WIDTH counters
HIST_WIDTH, 7, GHR width; legal range 1..IDX_WIDTH

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous reset, active-high
pred_pc  input  32  fetch PC to predict
pred_taken  output  1  predicted direction for pred_pc (combinational)
pred_idx  output  IDX_WIDTH  PHT index used for pred_pc; carried down pipeline
upd_valid  input  1  a conditional branch resolved this cycle
upd_idx  input  IDX_WIDTH  pred_idx captured when the branch was fetched
upd_taken  input  1  resolved outcome, 1 = taken
upd_pred  input  1  prediction that was used for this branch
ghr  output  HIST_WIDTH  current global history, LSB = most recent outcome
num_branches  output  32  resolved conditional branches since reset
num_mispredicts  output  32  mispredictions since reset

Behaviour:
- Index: pred_idx = pred_pc[IDX_WIDTH+1:2] XOR zero-extended ghr. PC bits [1:0] are ignored.
- Prediction:
  - pred_taken = MSB of pht[pred_idx].
  - Purely combinational from pred_pc and the current registered state. Zero latency.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Reset (rst=1 at posedge):
  - Every PHT entry becomes 01.
  - ghr becomes 0.
  - num_branches and num_mispredicts become 0.
  - rst has priority over upd_valid in the same cycle; that update is dropped.
  - Reset mid-operation discards all history. Outputs after the edge: pred_taken=0 for every PC; pred_idx=pred_pc[IDX_WIDTH+1:2].
- Update (upd_valid=1, rst=0, at posedge):
  - pht[upd_idx] takes its next counter value:
    - taken: 00→01, 01→10, 10→11, 11→11 (saturates).
    - not taken: 11→10, 10→01, 01→00, 00→00 (saturates).
  - ghr becomes {ghr[HIST_WIDTH-2:0], upd_taken}. When HIST_WIDTH=1, ghr becomes upd_taken.
  - num_branches increments by 1, wrapping 0xFFFFFFFF→0.
  - num_mispredicts increments by 1 iff upd_pred != upd_taken; same wrap rule.
  - No other entry changes.
- upd_valid=0: all state holds.
- Same-cycle predict/update:
  - No bypass. pred_idx and pred_taken use the pre-edge ghr and PHT contents, even when pred_idx == upd_idx.
  - New values are visible from the next cycle.
- GHR is updated only at resolution; there is no speculative history and no repair logic.
- A single update port; at most one update per cycle.

Test Plan:
1. Reset, then pred_pc=0x00000040 → pred_idx=0x10, pred_taken=0, ghr=0, both stats counters 0.
2. Three consecutive upd_valid cycles with upd_idx=5, upd_taken=1, upd_pred=0:
   - pht[5] goes 01→10→11→11.
   - ghr goes 0x01→0x03→0x07.
   - num_branches=3, num_mispredicts=3.
   - Then pred_pc=0x00000008 gives pred_idx=2^7=5 and pred_taken=1.
3. From reset, two updates with upd_idx=9, upd_taken=0, upd_pred=0:
   - pht[9] goes 01→00→00.
   - ghr stays 0; num_mispredicts stays 0.
   - One taken update then gives pht[9]=01, so pred_taken for idx 9 remains 0.
4. Collision: pred_pc=0x00000014 (idx 5, ghr 0) with upd_valid=1, upd_idx=5, upd_taken=1 in the same cycle:
   - That cycle, pred_taken=0.
   - Next cycle, ghr=1, so pred_pc=0x00000010 gives idx 5 and pred_taken=1.
5. Reset mid-operation: train idx 5 to 11 and ghr to 0x07, then assert rst together with upd_valid=1 → after the edge, all entries are 01, ghr=0, stats are 0, and the dropped update has no effect.
6. Stats wrap: force 2^32 updates (or preload via bench backdoor to 0xFFFFFFFF), then one more update → num_branches=0.

Source files
------------

// File: rtl/gshare_pht_if.sv
// Fetch-side prediction and execute-side resolution signals of the gshare predictor.
// The master is the pipeline; the slave is the predictor.
interface gshare_pht_if #(
    parameter int IDX_WIDTH  = 7,
    parameter int HIST_WIDTH = 7
);
    logic [31:0]           pred_pc;
    logic                  pred_taken;
    logic [IDX_WIDTH-1:0]  pred_idx;
    logic                  upd_valid;
    logic [IDX_WIDTH-1:0]  upd_idx;
    logic                  upd_taken;
    logic                  upd_pred;
    logic [HIST_WIDTH-1:0] ghr;
    logic [31:0]           num_branches;
    logic [31:0]           num_mispredicts;

    modport master (
        output pred_pc, upd_valid, upd_idx, upd_taken, upd_pred,
        input  pred_taken, pred_idx, ghr, num_branches, num_mispredicts
    );

    modport slave (
        input  pred_pc, upd_valid, upd_idx, upd_taken, upd_pred,
        output pred_taken, pred_idx, ghr, num_branches, num_mispredicts
    );
endinterface

// File: rtl/gshare_pht.sv
// Gshare direction predictor: 2-bit counter table indexed by PC xor global history,
// zero-latency lookup and single-port resolution update with statistics.
module gshare_pht #(
    parameter int IDX_WIDTH  = 7,
    parameter int HIST_WIDTH = 7
) (
    input  logic        clk,
    input  logic        rst,
    gshare_pht_if.slave bus
);
    localparam int DEPTH = 1 << IDX_WIDTH;

    logic [1:0]            pht [DEPTH];
    logic [HIST_WIDTH-1:0] ghr_q;
    logic [HIST_WIDTH-1:0] ghr_next;
    logic [31:0]           branches_q;
    logic [31:0]           mispredicts_q;
    logic [IDX_WIDTH-1:0]  ghr_ext;
    logic [IDX_WIDTH-1:0]  lookup_idx;
    logic [1:0]            upd_cur;
    logic [1:0]            upd_next;
    logic                  unused_pc_bits;

    assign ghr_ext    = IDX_WIDTH'(ghr_q);
    assign lookup_idx = bus.pred_pc[IDX_WIDTH+1:2] ^ ghr_ext;

    assign bus.pred_idx        = lookup_idx;
    assign bus.pred_taken      = pht[lookup_idx][1];
    assign bus.ghr             = ghr_q;
    assign bus.num_branches    = branches_q;
    assign bus.num_mispredicts = mispredicts_q;

    assign unused_pc_bits = ^{bus.pred_pc[31:IDX_WIDTH+2], bus.pred_pc[1:0]};

    // Saturating step toward the resolved direction.
    always_comb begin
        upd_cur  = pht[bus.upd_idx];
        upd_next = upd_cur;
        if (bus.upd_taken) begin
            if (upd_cur != 2'b11) upd_next = upd_cur + 2'b01;
        end else begin
            if (upd_cur != 2'b00) upd_next = upd_cur - 2'b01;
        end
    end

    if (HIST_WIDTH == 1) begin : g_hist_one
        assign ghr_next = bus.upd_taken;
    end else begin : g_hist_many
        assign ghr_next = {ghr_q[HIST_WIDTH-2:0], bus.upd_taken};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht[i] <= 2'b01;
            end
            ghr_q         <= '0;
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else if (bus.upd_valid) begin
            pht[bus.upd_idx] <= upd_next;
            ghr_q            <= ghr_next;
            branches_q       <= branches_q + 32'd1;
            if (bus.upd_pred != bus.upd_taken) begin
                mispredicts_q <= mispredicts_q + 32'd1;
            end
        end
    end
endmodule
